// File: rtl/saph_fpu_addsub_pkg.sv
// Shared FPU cluster types and constants for the saph_fpi link.
package saph_fpu_addsub_pkg;

  localparam int unsigned MODE_W = 4;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned EXT_W  = 27;
  localparam int unsigned SUM_W  = 28;
  localparam int unsigned LZC_W  = 5;
  localparam int unsigned EXPN_W = 10;

  typedef logic [31:0]       float;
  typedef logic [MODE_W-1:0] fpu_mode_t;

  localparam fpu_mode_t SAPH_FPU_FADD   = 4'h0;
  localparam fpu_mode_t SAPH_FPU_FSUB   = 4'h1;
  localparam float      SAPH_FLOAT_QNAN = 32'h7FC00000;

endpackage

// File: rtl/saph_fpi.sv
// Request/result link between a GPU-side initiator and one FPU unit.
interface saph_fpi
  import saph_fpu_addsub_pkg::*;
#(
  parameter int unsigned latency = 2
);
  logic      d_trig;
  float      d_lhs;
  float      d_rhs;
  fpu_mode_t d_mode;
  logic      d_ready;
  float      q_res;

  modport FPU (input d_trig, d_lhs, d_rhs, d_mode, output d_ready, q_res);
  modport GPU (output d_trig, d_lhs, d_rhs, d_mode, input d_ready, q_res);
endinterface

// File: rtl/saph_fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input yields W.
module saph_fpu_lzc
  import saph_fpu_addsub_pkg::*;
#(
  parameter int unsigned W  = SUM_W,
  parameter int unsigned CW = LZC_W
) (
  input  logic [W-1:0]  a,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = CW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (a[i]) cnt = CW'(W - 1 - i);
    end
  end
endmodule

// File: rtl/saph_fpu_addsub.sv
// Pipelined binary32 FADD/FSUB: align+add, normalise+round, optional delay, output register.
module saph_fpu_addsub
  import saph_fpu_addsub_pkg::*;
#(
  parameter int unsigned latency = 2
) (
  input logic  clk,
  input logic  rst,
  saph_fpi.FPU fpi
);
  localparam int unsigned RND_W = EXPN_W + 23;

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic [7:0]       exp;
    logic [SUM_W-1:0] sum;
    logic             byp;
    float             byp_res;
  } s1_t;

  typedef struct packed {
    logic valid;
    float res;
  } out_t;

  if (latency < 2) begin : g_bad_latency
    $error("saph_fpu_addsub: latency %0d is below 2", latency);
  end
  if (latency != fpi.latency) begin : g_latency_mismatch
    $error("saph_fpu_addsub: latency %0d differs from link latency", latency);
  end

  logic              accept;
  logic              sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic              swap, s_big, s_small;
  logic [7:0]        ea, eb, e_big, e_small, e_diff;
  logic [MANT_W-1:0] ma, mb, m_big, m_small;
  logic [EXT_W-1:0]  ext_small, shifted, lost_mask, aligned;
  s1_t               s1_n, s1_q;

  assign fpi.d_ready = !rst && (fpi.d_mode == SAPH_FPU_FADD || fpi.d_mode == SAPH_FPU_FSUB);
  assign accept      = fpi.d_trig && fpi.d_ready;

  // Unpack; a zero exponent field (zero or denormal) is treated as signed zero.
  always_comb begin
    sa     = fpi.d_lhs[31];
    sb     = fpi.d_rhs[31] ^ (fpi.d_mode == SAPH_FPU_FSUB);
    ea     = fpi.d_lhs[30:23];
    eb     = fpi.d_rhs[30:23];
    ma     = {1'b1, fpi.d_lhs[22:0]};
    mb     = {1'b1, fpi.d_rhs[22:0]};
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hFF) && (fpi.d_lhs[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (fpi.d_rhs[22:0] == 23'd0);
    a_nan  = (ea == 8'hFF) && (fpi.d_lhs[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (fpi.d_rhs[22:0] != 23'd0);
  end

  // Order by magnitude and align the smaller operand with a sticky lsb.
  always_comb begin
    swap      = (eb > ea) || ((eb == ea) && (mb > ma));
    s_big     = swap ? sb : sa;
    s_small   = swap ? sa : sb;
    e_big     = swap ? eb : ea;
    e_small   = swap ? ea : eb;
    m_big     = swap ? mb : ma;
    m_small   = swap ? ma : mb;
    e_diff    = e_big - e_small;
    ext_small = {m_small, 3'b000};
    shifted   = '0;
    lost_mask = '0;
    aligned   = EXT_W'(1);
    if (e_diff < 8'(EXT_W)) begin
      shifted   = ext_small >> e_diff;
      lost_mask = (EXT_W'(1) << e_diff) - EXT_W'(1);
      aligned   = shifted | EXT_W'(|(ext_small & lost_mask));
    end
  end

  always_comb begin
    s1_n       = '0;
    s1_n.valid = accept;
    s1_n.sign  = s_big;
    s1_n.exp   = e_big;
    if (s_big ^ s_small) s1_n.sum = {1'b0, m_big, 3'b000} - {1'b0, aligned};
    else                 s1_n.sum = {1'b0, m_big, 3'b000} + {1'b0, aligned};
    s1_n.byp = 1'b1;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) s1_n.byp_res = SAPH_FLOAT_QNAN;
    else if (a_inf)             s1_n.byp_res = {sa, 8'hFF, 23'd0};
    else if (b_inf)             s1_n.byp_res = {sb, 8'hFF, 23'd0};
    else if (a_zero && b_zero)  s1_n.byp_res = {sa & sb, 31'd0};
    else if (a_zero)            s1_n.byp_res = {sb, fpi.d_rhs[30:0]};
    else if (b_zero)            s1_n.byp_res = fpi.d_lhs;
    else                        s1_n.byp     = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) s1_q <= '0;
    else     s1_q <= s1_n;
  end

  logic [LZC_W-1:0]  lz, sh;
  logic              carry, inc;
  logic [EXT_W-1:0]  norm;
  logic [EXPN_W-1:0] e_norm, e_rnd;
  logic [RND_W-1:0]  rnd;
  float              res2;
  out_t              s2, tail;

  saph_fpu_lzc #(.W(SUM_W), .CW(LZC_W)) u_lzc (.a(s1_q.sum), .cnt(lz));

  // Normalise, round to nearest even; the rounding carry ripples into the exponent.
  always_comb begin
    carry = s1_q.sum[SUM_W-1];
    sh    = lz - LZC_W'(1);
    if (carry) begin
      norm   = {s1_q.sum[SUM_W-1:2], |s1_q.sum[1:0]};
      e_norm = EXPN_W'(s1_q.exp) + EXPN_W'(1);
    end else begin
      norm   = EXT_W'(s1_q.sum << sh);
      e_norm = EXPN_W'(s1_q.exp) - EXPN_W'(sh);
    end
    inc   = norm[2] && (norm[1] || norm[0] || norm[3]);
    rnd   = {e_norm, norm[25:3]} + RND_W'(inc);
    e_rnd = rnd[RND_W-1:23];
    res2  = {s1_q.sign, e_rnd[7:0], rnd[22:0]};
    if (!norm[EXT_W-1])                         res2 = '0;
    else if (e_rnd[EXPN_W-1] || e_rnd == '0)    res2 = {s1_q.sign, 31'd0};
    else if (e_rnd >= EXPN_W'(255))             res2 = {s1_q.sign, 8'hFF, 23'd0};
    if (s1_q.byp) res2 = s1_q.byp_res;
    s2.valid = s1_q.valid;
    s2.res   = res2;
  end

  if (latency > 2) begin : g_delay
    out_t dly [latency-2];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < latency - 2; i++) dly[i] <= '0;
      end else begin
        dly[0] <= s2;
        for (int unsigned i = 1; i < latency - 2; i++) dly[i] <= dly[i-1];
      end
    end
    assign tail = dly[latency-3];
  end else begin : g_no_delay
    assign tail = s2;
  end

  float q_res_r;
  always_ff @(posedge clk) begin
    if (rst)             q_res_r <= '0;
    else if (tail.valid) q_res_r <= tail.res;
  end
  assign fpi.q_res = q_res_r;

endmodule

// File: tb/tb_saph_fpu_addsub.sv
// Bench for saph_fpu_addsub at latency 2 and 3 against a real-arithmetic reference.
module tb_saph_fpu_addsub;
  import saph_fpu_addsub_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   started  = 0;

  saph_fpi #(.latency(2)) fpi2 ();
  saph_fpi #(.latency(3)) fpi3 ();

  saph_fpu_addsub #(.latency(2)) dut2 (.clk(clk), .rst(rst), .fpi(fpi2));
  saph_fpu_addsub #(.latency(3)) dut3 (.clk(clk), .rst(rst), .fpi(fpi3));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: IEEE rules on special values, real arithmetic for finite sums.
  function automatic real f2r(input logic [31:0] f);
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic [63:0] d;
    logic [23:0] m;
    int          e;
    d = $realtobits(x);
    e = int'(d[62:52]) - 1023 + 127;
    m = {1'b1, d[51:29]};
    if (d[28] && ((|d[27:0]) || m[0])) begin
      if (m == 24'hFFFFFF) begin
        m = 24'h800000;
        e = e + 1;
      end else begin
        m = m + 24'd1;
      end
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0)   return {d[63], 31'd0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] mode);
    logic [31:0] bb;
    bit na, nb, ia, ib, za, zb;
    real x;
    bb = {b[31] ^ (mode == 4'h1), b[30:0]};
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    za = (a[30:23] == 8'h00);
    zb = (b[30:23] == 8'h00);
    if (na || nb) return 32'h7FC00000;
    if (ia && ib) return (a[31] == bb[31]) ? a : 32'h7FC00000;
    if (ia) return a;
    if (ib) return bb;
    if (za && zb) return {a[31] & bb[31], 31'd0};
    if (za) return bb;
    if (zb) return a;
    x = f2r(a) + f2r(bb);
    if (x == 0.0) return 32'h0;
    return r2f(x);
  endfunction

  function automatic bit model_ready(input logic [3:0] m, input logic r);
    return !r && (m == 4'h0 || m == 4'h1);
  endfunction

  typedef struct {
    int          upd;
    logic [31:0] val;
  } ent_t;
  ent_t        pend2[$];
  ent_t        pend3[$];
  logic [31:0] exp2 = 32'h0;
  logic [31:0] exp3 = 32'h0;

  // Expected output register of each instance, advanced at every edge.
  always @(posedge clk) begin
    logic [31:0] r;
    cyc = cyc + 1;
    if (rst) begin
      pend2.delete();
      pend3.delete();
      exp2 = 32'h0;
      exp3 = 32'h0;
    end else begin
      if (pend2.size() > 0 && pend2[0].upd == cyc) begin
        exp2 = pend2[0].val;
        void'(pend2.pop_front());
      end
      if (pend3.size() > 0 && pend3[0].upd == cyc) begin
        exp3 = pend3[0].val;
        void'(pend3.pop_front());
      end
      if (fpi2.d_trig && model_ready(fpi2.d_mode, rst)) begin
        r = ref_add(fpi2.d_lhs, fpi2.d_rhs, fpi2.d_mode);
        pend2.push_back('{cyc + 1, r});
        pend3.push_back('{cyc + 2, r});
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("q_res_lat2", fpi2.q_res, exp2);
      check("q_res_lat3", fpi3.q_res, exp3);
      check("d_ready_lat2", {31'd0, fpi2.d_ready}, {31'd0, model_ready(fpi2.d_mode, rst)});
      check("d_ready_lat3", {31'd0, fpi3.d_ready}, {31'd0, model_ready(fpi3.d_mode, rst)});
    end
  end

  task automatic set_in(input logic trig, input logic [31:0] lhs, input logic [31:0] rhs,
                        input logic [3:0] mode);
    fpi2.d_trig = trig; fpi2.d_lhs = lhs; fpi2.d_rhs = rhs; fpi2.d_mode = mode;
    fpi3.d_trig = trig; fpi3.d_lhs = lhs; fpi3.d_rhs = rhs; fpi3.d_mode = mode;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One request in cycle t; literal result checked at t+2 (lat 2) and t+3 (lat 3).
  task automatic run_single(input string name, input logic [31:0] lhs, input logic [31:0] rhs,
                            input logic [3:0] mode, input logic [31:0] want);
    set_in(1'b1, lhs, rhs, mode);
    #1 check({name, "_ready"}, {31'd0, fpi2.d_ready}, 32'd1);
    next_cycle();
    set_in(1'b0, 32'h0, 32'h0, 4'h0);
    next_cycle();
    check({name, "_lat2"}, fpi2.q_res, want);
    next_cycle();
    check({name, "_lat3"}, fpi3.q_res, want);
  endtask

  initial begin
    logic [31:0] b2b_lhs [4];
    logic [31:0] b2b_res [4];
    b2b_lhs = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    b2b_res = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

    set_in(1'b0, 32'h0, 32'h0, 4'h0);
    rst = 1'b1;
    repeat (3) next_cycle();
    check("reset_ready", {31'd0, fpi2.d_ready}, 32'd0);
    rst = 1'b0;
    next_cycle();
    check("reset_q_lat2", fpi2.q_res, 32'h0);
    check("reset_q_lat3", fpi3.q_res, 32'h0);

    run_single("add_1_2",        32'h3F800000, 32'h40000000, 4'h0, 32'h40400000);
    run_single("sub_1_1",        32'h3F800000, 32'h3F800000, 4'h1, 32'h00000000);
    run_single("negzero_sum",    32'h80000000, 32'h80000000, 4'h0, 32'h80000000);
    run_single("denorm_zero",    32'h00000001, 32'h00000000, 4'h0, 32'h00000000);
    run_single("inf_minus_inf",  32'h7F800000, 32'hFF800000, 4'h0, 32'h7FC00000);
    run_single("overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 4'h0, 32'h7F800000);
    run_single("nan_in",         32'h7FC00001, 32'h3F800000, 4'h0, 32'h7FC00000);
    run_single("tie_even",       32'h3F800000, 32'h33800000, 4'h0, 32'h3F800000);
    run_single("above_half",     32'h3F800000, 32'h33800001, 4'h0, 32'h3F800001);
    run_single("tie_odd",        32'h3F800001, 32'h33800000, 4'h0, 32'h3F800002);
    run_single("sub_neg",        32'h3F800000, 32'h40000000, 4'h1, 32'hBF800000);
    run_single("inf_plus_fin",   32'h7F800000, 32'h3F800000, 4'h0, 32'h7F800000);
    run_single("ftz_result",     32'h00C00000, 32'h00800000, 4'h1, 32'h00000000);
    run_single("zero_minus_two", 32'h00000000, 32'h40000000, 4'h1, 32'hC0000000);

    // Back-to-back accepts, results in consecutive cycles.
    for (int k = 0; k < 7; k++) begin
      if (k < 4) set_in(1'b1, b2b_lhs[k], b2b_lhs[k], 4'h0);
      else       set_in(1'b0, 32'h0, 32'h0, 4'h0);
      if (k >= 2 && k < 6) check($sformatf("b2b_lat2_%0d", k - 2), fpi2.q_res, b2b_res[k-2]);
      if (k >= 3)          check($sformatf("b2b_lat3_%0d", k - 3), fpi3.q_res, b2b_res[k-3]);
      next_cycle();
    end

    // Unsupported mode is never accepted; output holds.
    set_in(1'b1, 32'h3F800000, 32'h3F800000, 4'h5);
    #1 check("unsup_ready", {31'd0, fpi2.d_ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      check($sformatf("unsup_hold_lat2_%0d", k), fpi2.q_res, 32'h41000000);
      check($sformatf("unsup_hold_lat3_%0d", k), fpi3.q_res, 32'h41000000);
    end
    set_in(1'b0, 32'h0, 32'h0, 4'h0);
    next_cycle();

    // Reset in the third cycle of a burst discards everything in flight.
    for (int k = 0; k < 7; k++) begin
      if (k < 3) set_in(1'b1, b2b_lhs[k], b2b_lhs[k], 4'h0);
      else       set_in(1'b0, 32'h0, 32'h0, 4'h0);
      rst = (k == 2);
      if (k == 2) begin
        check("rst_first_lat2", fpi2.q_res, 32'h40000000);
        #1 check("rst_ready", {31'd0, fpi2.d_ready}, 32'd0);
      end
      if (k >= 3) begin
        check($sformatf("rst_clear_lat2_%0d", k), fpi2.q_res, 32'h0);
        check($sformatf("rst_clear_lat3_%0d", k), fpi3.q_res, 32'h0);
      end
      next_cycle();
    end
    rst = 1'b0;

    run_single("after_reset", 32'h40400000, 32'h3F800000, 4'h1, 32'h40000000);
    repeat (3) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/saph_fpu_addsub.md
# saph_fpu_addsub

- Fully pipelined binary32 add/subtract unit serving the FPU end of the `saph_fpi` interface.
- Accepts one FADD/FSUB request per cycle from a GPU-side initiator, such as the rasterizer's float incrementers.
- Returns the rounded result on `q_res` exactly `latency` cycles after acceptance.
- Sits in the shared FPU cluster, one instance per `saph_fpi` link.

## Interface
- `latency`, default 2: cycles from acceptance to result. Legal range ≥2. Must equal `fpi.latency`; an `initial` check raises `$error` on mismatch.
- `clk`  in  1  core clock.
- `rst`  in  1  reset: synchronous, active-high.
- `fpi`  `saph_fpi.FPU`  interface bundle:
  - `d_trig` in, request.
  - `d_lhs`/`d_rhs` in, float operands.
  - `d_mode` in.
  - `d_ready` out.
  - `q_res` out, float.

## Operation
- Accept condition: `d_ready = !rst && (d_mode == SAPH_FPU_FADD || d_mode == SAPH_FPU_FSUB)`. Purely combinational, with no backpressure.
  - The transfer happens in any cycle where `d_trig && d_ready`.
  - Unsupported modes get `d_ready=0` and are never accepted.
- FSUB: flip the sign of `rhs` at unpack.
- Format: IEEE-754 binary32 with these decided simplifications:
  - Denormal inputs are treated as signed zero.
  - Denormal results flush to zero, keeping the result sign.
  - Rounding is round-to-nearest-even only.
  - No exception flags.
- Special cases, resolved in stage 1 and carried as a bypass:
  - Any NaN operand → `0x7FC00000`.
  - inf + (−inf) → `0x7FC00000`.
  - inf ± finite → that inf.
  - Both zero → −0 only if both are −0, else +0.
  - One zero → the other operand, unchanged.
- Stage 1 (datapath):
  - Unpack, hidden bit → 24-bit mantissa.
  - Swap so |a| ≥ |b|, comparing exponent then mantissa.
  - Right-shift b by the exponent difference into 27 bits (24 + guard/round/sticky). Shift ≥27 leaves only the sticky bit.
  - Add or subtract the magnitudes into a 28-bit sum. Register the result.
- Stage 2 (datapath):
  - Carry-out: shift right 1, OR the lost bit into sticky, exponent +1.
  - Else: left-normalise by the leading-zero count, exponent −lzc.
  - Exact cancellation gives +0.
  - RNE: increment if `g && (r || s || lsb)`. Mantissa overflow on rounding → exponent +1.
  - Biased exponent ≥255 → signed inf. Exponent ≤0 → signed zero.
- Output:
  - `q_res` is a register written only when a valid result emerges; otherwise it holds its last value.
  - Extra latency beyond 2 is a chain of `latency−2` valid+data delay registers inserted before the output register.
- Reset:
  - All valid bits are cleared and `q_res` is set to 0.
  - In-flight requests are discarded; no result of a request accepted before or during `rst` ever appears.

## Timing
- Request accepted in cycle t (sampled at the posedge ending t). `q_res` is valid throughout cycle t+`latency` and is sampled by the initiator at the end of that cycle.
- Throughput is 1 result/cycle, in order. There are no stalls and no hazards between back-to-back requests.
- `d_ready` responds in the same cycle to `d_mode` and `rst`. It does not depend on `d_trig`.
- `q_res` after reset: 0x00000000 until the first result.

## Structure
- Shared `saph_defines.svh`:
  - `float` typedef.
  - `SAPH_FPU_FADD`.
  - `SAPH_FPU_FSUB`, added if absent.
  - `SAPH_FLOAT_QNAN` (`32'h7FC00000`).
- Sub-module `saph_fpu_lzc`: combinational 28-bit leading-zero counter (5-bit output), reusable by future mul/convert units.
- Pipeline registers are a per-stage packed struct local to this module: valid, sign, exponent, mantissa, special-case bypass.

## Test plan
1. FADD `0x3F800000` + `0x40000000` with `d_trig` in cycle t, `latency`=2 → `d_ready`=1 in t; `q_res`=`0x40400000` in t+2.
2. FSUB 1.0−1.0 → `0x00000000`; FADD `0x80000000`+`0x80000000` → `0x80000000`; FADD `0x00000001`+`0x00000000` → `0x00000000`.
3. Specials:
   - `0x7F800000`+`0xFF800000` → `0x7FC00000`.
   - `0x7F7FFFFF`+`0x7F7FFFFF` → `0x7F800000`.
   - `0x7FC00001`+1.0 → `0x7FC00000`.
4. Rounding:
   - `0x3F800000`+`0x33800000` → `0x3F800000` (tie to even).
   - `0x3F800000`+`0x33800001` → `0x3F800001`.
   - `0x3F800001`+`0x33800000` → `0x3F800002`.
5. Pipelining and reset:
   - Back-to-back accepts of 1+1, 2+2, 3+3, 4+4 in cycles t..t+3 → results `0x40000000`, `0x40800000`, `0x40C00000`, `0x41000000` in t+2..t+5.
   - Repeat with `rst` high in cycle t+2 → no further results appear, `q_res`=0 from t+3.
6. `d_mode` set to an unsupported code with `d_trig`=1 → `d_ready`=0 and `q_res` unchanged. Repeat the scenario-1 check at `latency`=3 → result in t+3.
